// File: rtl/long_prim_pkg.sv
// long_prim_pkg: shared primitive-stage and segment-count helpers for long_prim_pipe.
package long_prim_pkg;
  localparam int MAX_W = 256;
  // Pairs are independent, so callers zero-extend to MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] prim_stage(input logic [MAX_W-1:0] x);
    logic [MAX_W-1:0] y;
    for (int j = 0; j < MAX_W/2; j++) begin
      y[2*j+1] = x[2*j+1] ^ x[2*j];
      y[2*j]   = ~x[2*j];
    end
    return y;
  endfunction
  function automatic int nreg(input int depth, input int reg_every);
    return (depth + reg_every - 1) / reg_every;
  endfunction
endpackage

// File: rtl/long_prim_seg.sv
// long_prim_seg: N combinational primitive stages followed by one valid/ready register slot.
module long_prim_seg
  import long_prim_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  logic [W-1:0] data_d, data_q;
  logic         valid_q;
  always_comb begin
    data_d = in_data_i;
    for (int i = 0; i < N; i++) data_d = W'(prim_stage(MAX_W'(data_d)));
  end
  assign in_ready_o  = !rst && (!valid_q || out_ready_i);
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= data_d;
    end
  end
endmodule

// File: rtl/long_prim_pipe.sv
// long_prim_pipe: DEPTH primitive stages split into registered segments with valid/ready flow.
// Define LONG_PRIM_PIPE_STATS_EN to add output transfer and stall counters.
module long_prim_pipe
  import long_prim_pkg::*;
#(
  parameter int IO_PAIRS  = 4,
  parameter int DEPTH     = 8,
  parameter int REG_EVERY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*IO_PAIRS-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*IO_PAIRS-1:0] out_data
`ifdef LONG_PRIM_PIPE_STATS_EN
  ,
  output logic [31:0]           stat_xfer_cnt,
  output logic [31:0]           stat_stall_cnt
`endif
);
  localparam int W    = 2 * IO_PAIRS;
  localparam int NREG = nreg(DEPTH, REG_EVERY);
  for (genvar k = 0; k < NREG; k++) begin : g
    localparam int N = (k == NREG - 1) ? DEPTH - (NREG - 1) * REG_EVERY : REG_EVERY;
    logic         iv, irdy, ov, ordy;
    logic [W-1:0] id, od;
    if (k == 0) begin : h
      assign iv = in_valid;
      assign id = in_data;
    end else begin : h
      assign iv = g[k-1].ov;
      assign id = g[k-1].od;
    end
    if (k == NREG - 1) begin : t
      assign ordy = out_ready;
    end else begin : t
      assign ordy = g[k+1].irdy;
    end
    long_prim_seg #(.W(W), .N(N)) u_seg (
      .clk        (clk),
      .rst        (rst),
      .in_valid_i (iv),
      .in_ready_o (irdy),
      .in_data_i  (id),
      .out_valid_o(ov),
      .out_ready_i(ordy),
      .out_data_o (od)
    );
  end
  assign in_ready  = g[0].irdy;
  assign out_valid = g[NREG-1].ov;
  assign out_data  = g[NREG-1].od;
`ifdef LONG_PRIM_PIPE_STATS_EN
  logic [31:0] xfer_q, stall_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_q + 32'(out_valid && out_ready);
      stall_q <= stall_q + 32'(out_valid && !out_ready);
    end
  end
  assign stat_xfer_cnt  = xfer_q;
  assign stat_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_long_prim_pipe.sv
// tb_long_prim_pipe: scoreboarded random and directed checks on four pipe configurations.
module tb_long_prim_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Closed form of n stages on a pair (a=odd, b=even): b ^= n odd, a ^= (b if n odd) ^ parity(n/2).
  function automatic logic [31:0] model(input logic [31:0] x, input int pairs, input int n);
    logic [31:0] y;
    logic [31:0] nn;
    y  = '0;
    nn = n;
    for (int j = 0; j < pairs; j++) begin
      y[2*j]   = x[2*j] ^ nn[0];
      y[2*j+1] = x[2*j+1] ^ (x[2*j] & nn[0]) ^ nn[1];
    end
    return y;
  endfunction
  logic       v0 = 0, or0 = 1, r0, ov0;
  logic [7:0] d0 = 0, od0;
  logic       v1 = 0, or1 = 1, r1, ov1;
  logic [7:0] d1 = 0, od1;
  logic       v2 = 0, or2 = 1, r2, ov2;
  logic [3:0] d2 = 0, od2;
  logic       v3 = 0, or3 = 1, r3, ov3;
  logic [1:0] d3 = 0, od3;
`ifdef LONG_PRIM_PIPE_STATS_EN
  logic [31:0] x0, s0, x1, s1, x2, s2, x3, s3;
`endif
  long_prim_pipe u0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(r0), .in_data(d0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0)
`ifdef LONG_PRIM_PIPE_STATS_EN
    , .stat_xfer_cnt(x0), .stat_stall_cnt(s0)
`endif
  );
  long_prim_pipe #(.IO_PAIRS(4), .DEPTH(7), .REG_EVERY(3)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1)
`ifdef LONG_PRIM_PIPE_STATS_EN
    , .stat_xfer_cnt(x1), .stat_stall_cnt(s1)
`endif
  );
  long_prim_pipe #(.IO_PAIRS(2), .DEPTH(1), .REG_EVERY(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2), .in_data(d2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2)
`ifdef LONG_PRIM_PIPE_STATS_EN
    , .stat_xfer_cnt(x2), .stat_stall_cnt(s2)
`endif
  );
  long_prim_pipe #(.IO_PAIRS(1), .DEPTH(2), .REG_EVERY(1)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3)
`ifdef LONG_PRIM_PIPE_STATS_EN
    , .stat_xfer_cnt(x3), .stat_stall_cnt(s3)
`endif
  );
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int got0 = 0, got1 = 0, first1 = -1, last1 = -1;
  logic hold0 = 0;
  logic [7:0] hd0 = 0;
  // Monitors: push expected on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q0.delete();
      q1.delete();
      hold0 = 0;
    end else begin
      if (hold0) begin
        chk("u0_hold_valid", 32'(ov0), 32'd1);
        chk("u0_hold_data", 32'(od0), 32'(hd0));
      end
      hold0 = ov0 && !or0;
      hd0   = od0;
      if (ov0 && or0) begin
        got0++;
        if (q0.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL u0_extra: out_data %0h with empty scoreboard", od0);
        end else chk("u0_data", 32'(od0), 32'(q0.pop_front()));
      end
      if (v0 && r0) q0.push_back(8'(model(32'(d0), 4, 8)));
      if (ov1 && or1) begin
        got1++;
        if (first1 < 0) first1 = cyc;
        last1 = cyc;
        if (q1.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL u1_extra: out_data %0h with empty scoreboard", od1);
        end else chk("u1_data", 32'(od1), 32'(q1.pop_front()));
      end
      if (v1 && r1) q1.push_back(8'(model(32'(d1), 4, 7)));
    end
  end
  logic rnd0 = 0;
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd0) or0 = 1'($urandom_range(0, 1));
  endtask
  task automatic send0(input logic [7:0] x);
    logic a;
    int n;
    d0 = x;
    v0 = 1;
    n  = 0;
    do begin
      @(negedge clk);
      a = r0;
      step();
      n++;
    end while (!a && n < 500);
    v0 = 0;
    if (!a) begin
      checks++;
      fails++;
      $display("FAIL u0_send_timeout: word %0h not accepted in %0d cycles", x, n);
    end
  endtask
  task automatic send1(input logic [7:0] x, output int n);
    logic a;
    d1 = x;
    v1 = 1;
    n  = 0;
    do begin
      @(negedge clk);
      a = r1;
      step();
      n++;
    end while (!a && n < 500);
    v1 = 0;
  endtask
  task automatic drain0();
    int n = 0;
    or0 = 1;
    while (q0.size() != 0 && n < 500) begin
      step();
      n++;
    end
    chk("u0_drained", q0.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    int lat, n;
    logic [7:0] w [4];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(r0), 32'd0);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", 32'(od0), 32'd0);
    rst = 0;
    #1;
    chk("idle_in_ready", 32'(r0), 32'd1);
    // Scenario 1: 8 stages are identity, latency NREG=4.
    send0(8'hA5);
    lat = 1;
    while (!ov0 && lat < 20) begin
      step();
      lat++;
    end
    chk("u0_latency", lat, 4);
    chk("u0_a5", 32'(od0), 32'hA5);
    step();
    // Scenario 3: one stage, latency 1.
    chk("u2_ready", 32'(r2), 32'd1);
    d2 = 4'b0000;
    v2 = 1;
    step();
    v2 = 0;
    chk("u2_valid", 32'(ov2), 32'd1);
    chk("u2_data", 32'(od2), 32'b0101);
    // Scenario 2: two single-stage segments invert the odd bit.
    chk("u3_idle_valid", 32'(ov3), 32'd0);
    d3 = 2'b01;
    v3 = 1;
    step();
    d3 = 2'b10;
    step();
    v3 = 0;
    chk("u3_valid0", 32'(ov3), 32'd1);
    chk("u3_data0", 32'(od3), 32'b11);
    step();
    chk("u3_valid1", 32'(ov3), 32'd1);
    chk("u3_data1", 32'(od3), 32'b00);
    // Scenario 6: 7 stages in 3 segments, streamed back-to-back.
    for (int i = 0; i < 30; i++) begin
      send1(8'($urandom), n);
      chk("u1_accept_cycles", n, 1);
    end
    n = 0;
    while (got1 < 30 && n < 200) begin
      step();
      n++;
    end
    chk("u1_count", got1, 30);
    chk("u1_span", last1 - first1, 29);
`ifdef LONG_PRIM_PIPE_STATS_EN
    chk("u1_xfer_cnt", x1, 30);
`endif
    // Scenario 4: 100 random words with random backpressure.
    rnd0 = 1;
    for (int i = 0; i < 100; i++) begin
      send0(8'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd0 = 0;
    drain0();
    chk("u0_count", got0, 101);
    // Scenario 5: fill, stall 10 cycles, then reset mid-stream.
    rst = 1;
    step();
    rst = 0;
    or0 = 0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      send0(w[i]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(r0), 32'd0);
      chk("stall_valid", 32'(ov0), 32'd1);
      chk("stall_data", 32'(od0), model(32'(w[0]), 4, 8));
      step();
    end
`ifdef LONG_PRIM_PIPE_STATS_EN
    chk("stall_cnt", s0, 10);
`endif
    rst = 1;
    #1;
    chk("midrst_in_ready", 32'(r0), 32'd0);
    step();
    chk("postrst_valid", 32'(ov0), 32'd0);
    chk("postrst_data", 32'(od0), 32'd0);
`ifdef LONG_PRIM_PIPE_STATS_EN
    chk("postrst_stall_cnt", s0, 0);
    chk("postrst_xfer_cnt", x0, 0);
`endif
    rst = 0;
    // Full pipeline accepts a push in the same cycle as a pop.
    got0 = 0;
    for (int i = 0; i < 4; i++) send0(8'($urandom));
    chk("full_in_ready", 32'(r0), 32'd0);
    or0 = 1;
    #1;
    chk("full_pushpop_ready", 32'(r0), 32'd1);
    send0(8'($urandom));
    drain0();
    chk("refill_count", got0, 5);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/long_prim_pipe.md
LONG_PRIM_PIPE -- requirements
Module: long_prim_pipe

Interface
REQ-001 SHALL have parameter IO_PAIRS, default 4: number of bit pairs; data width W = 2*IO_PAIRS.
REQ-002 SHALL have parameter DEPTH, default 8: number of serial primitive stages, legal range >= 1.
REQ-003 SHALL have parameter REG_EVERY, default 2: primitive stages per pipeline register, legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: upstream word valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts word this cycle.
REQ-008 SHALL have port in_data, input, W: input word.
REQ-009 SHALL have port out_valid, output, 1: out_data valid.
REQ-010 SHALL have port out_ready, input, 1: downstream accepts.
REQ-011 SHALL have port out_data, output, W: result word.

Function
REQ-012 Each primitive stage, for pair j: o[2j+1] = i[2j+1] XOR i[2j]; o[2j] = NOT i[2j].
REQ-013 Stages SHALL be grouped into NREG = ceil(DEPTH/REG_EVERY) segments; every segment except the last holds REG_EVERY stages; the last holds the remainder (DEPTH - (NREG-1)*REG_EVERY).
REQ-014 Each segment SHALL end in one data register plus one valid flag; out_data/out_valid SHALL come straight from the last segment's register, with no combinational path from in_data.
REQ-015 Latency SHALL be exactly NREG cycles from an accepted input to out_valid, when no stall occurs.
REQ-016 Transfer occurs on valid AND ready, at both ports; words SHALL never be dropped, duplicated or reordered.
REQ-017 Segment k SHALL load when its register is empty or when segment k+1 (or the output, for the last segment) accepts in the same cycle; in_ready = segment-0 load condition.
REQ-018 With out_ready held high, throughput SHALL be one word per cycle; a full pipeline with out_ready low SHALL hold all registers and hold in_ready low.
REQ-019 out_valid and out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 In a simultaneous pop and push on a full pipeline, the block SHALL accept both in the same cycle.

Reset
REQ-021 rst SHALL clear every valid flag to 0; out_valid=0 in the cycle after rst is sampled high.
REQ-022 Data registers SHALL reset to 0, so out_data = 0 after reset.
REQ-023 rst asserted mid-stream SHALL discard all in-flight words; in_ready SHALL be 0 while rst=1.

Configuration
REQ-024 Macro LONG_PRIM_PIPE_STATS_EN, when defined, SHALL add output stat_xfer_cnt[31:0]: count of output transfers.
REQ-025 It SHALL also add output stat_stall_cnt[31:0]: count of cycles with out_valid=1 and out_ready=0.
REQ-026 Both counters SHALL reset to 0 on rst and wrap modulo 2^32.
REQ-027 Without the macro, these ports and their logic SHALL be absent, and the remaining behaviour SHALL be unchanged.

Structure
REQ-028 Package long_prim_pkg SHALL hold the prim_stage function (one W-wide stage, width-generic via parameter) and the NREG computation function.
REQ-029 Sub-module long_prim_seg SHALL implement N combinational stages plus one handshake register slot; long_prim_pipe SHALL instantiate it NREG times.

Verification
REQ-030 Scenario 1: IO_PAIRS=4, DEPTH=8, REG_EVERY=2; push 0xA5 -> 0xA5 appears after 4 cycles. 8 stages = identity, because 4 stages = identity.
REQ-031 Scenario 2: DEPTH=2, REG_EVERY=1, IO_PAIRS=1; push 2'b01, 2'b10 -> 2'b11, 2'b00 after 2 cycles. 2 stages invert the odd bit only.
REQ-032 Scenario 3: DEPTH=1, IO_PAIRS=2; push 4'b0000 -> 4'b0101, latency 1.
REQ-033 Scenario 4: default parameters, 100 random words, out_ready randomly 50% -> in-order exact match to the model, and no loss.
REQ-034 Scenario 5: fill pipeline, hold out_ready=0 for 10 cycles, then assert rst -> in_ready=0 during the stall, out_data stable, out_valid=0 after reset; stat_stall_cnt=10 before rst, 0 after (macro defined).
REQ-035 Scenario 6: DEPTH=7, REG_EVERY=3 -> NREG=3, last segment 1 stage; streamed output equals 7-stage model at 1 word/cycle.
